// File: rtl/aes_pkg.sv
// Shared AES constants and FSM state type for the inverse-cipher datapath.
package aes_pkg;

  localparam int STATE_W  = 128;
  localparam int COL_W    = 32;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Column 0 occupies the most significant word of the state.
  function automatic int col_msb(input int col);
    return STATE_W - 1 - COL_W * col;
  endfunction

endpackage

// File: rtl/inv_mix_columns.sv
// InvMixColumns on one 32-bit column (byte 0 = [31:24]) over GF(2^8).
module inv_mix_columns (
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] b  [4];
  logic [7:0] x2 [4];
  logic [7:0] x4 [4];
  logic [7:0] x8 [4];
  logic [7:0] m09[4];
  logic [7:0] m0b[4];
  logic [7:0] m0d[4];
  logic [7:0] m0e[4];

  // Build 9/b/d/e multiples from the doubling chain instead of a generic multiplier.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      b[i]   = col_in[31 - 8 * i -: 8];
      x2[i]  = xtime(b[i]);
      x4[i]  = xtime(x2[i]);
      x8[i]  = xtime(x4[i]);
      m09[i] = x8[i] ^ b[i];
      m0b[i] = x8[i] ^ x2[i] ^ b[i];
      m0d[i] = x8[i] ^ x4[i] ^ b[i];
      m0e[i] = x8[i] ^ x4[i] ^ x2[i];
    end
  end

  assign col_out[31:24] = m0e[0] ^ m0b[1] ^ m0d[2] ^ m09[3];
  assign col_out[23:16] = m09[0] ^ m0e[1] ^ m0b[2] ^ m0d[3];
  assign col_out[15:8]  = m0d[0] ^ m09[1] ^ m0e[2] ^ m0b[3];
  assign col_out[7:0]   = m0b[0] ^ m0d[1] ^ m09[2] ^ m0e[3];

endmodule

// File: rtl/inv_addkey_mix_seq.sv
// AES decryption-round sequencer: AddRoundKey, then column-serial InvMixColumns.
// Optional macro AES_STATE_ZEROIZE_EN clears the state buffer on the output handshake.
module inv_addkey_mix_seq
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         i_Clk,
  input  logic         i_Rst_n,
  input  logic         i_Valid,
  output logic         o_Ready,
  input  logic [127:0] i_Data,
  input  logic [127:0] i_Key,
  input  logic         i_Skip_Mix,
  output logic         o_Valid,
  input  logic         i_Ready,
  output logic [127:0] o_Data
);

  localparam int         GROUPS     = NUM_COLS / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_GROUP = 2'(GROUPS - 1);

  state_t             state;
  logic [1:0]         mix_cnt;
  logic [STATE_W-1:0] buffer;
  logic               skip_flag;

  logic [COL_W-1:0]   cols    [NUM_COLS];
  logic [COL_W-1:0]   new_cols[NUM_COLS];
  logic [COL_W-1:0]   mix_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0]   mix_out [COLS_PER_CYCLE];
  logic [1:0]         col_idx [COLS_PER_CYCLE];
  logic [STATE_W-1:0] mixed_buffer;
  logic               accept;

  // Each column slot takes the InvMixColumns result only while its group is active.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    assign cols[c]     = buffer[col_msb(c) -: COL_W];
    assign new_cols[c] = (mix_cnt == 2'(c / COLS_PER_CYCLE)) ?
                         mix_out[c % COLS_PER_CYCLE] : cols[c];
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
    assign col_idx[g] = mix_cnt * 2'(COLS_PER_CYCLE) + 2'(g);
    assign mix_in[g]  = cols[col_idx[g]];

    inv_mix_columns u_inv_mix_columns (
      .col_in  (mix_in[g]),
      .col_out (mix_out[g])
    );
  end

  assign mixed_buffer = {new_cols[0], new_cols[1], new_cols[2], new_cols[3]};

  // DONE with downstream ready frees the slot in the same cycle, so no bubble.
  assign o_Ready = (state == IDLE) | ((state == DONE) & i_Ready);
  assign accept  = o_Ready & i_Valid;
  assign o_Data  = buffer;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state     <= IDLE;
      mix_cnt   <= 2'd0;
      buffer    <= '0;
      skip_flag <= 1'b0;
      o_Valid   <= 1'b0;
    end else if (accept) begin
      buffer    <= i_Data ^ i_Key;
      skip_flag <= i_Skip_Mix;
      mix_cnt   <= 2'd0;
      state     <= i_Skip_Mix ? DONE : MIX;
      o_Valid   <= i_Skip_Mix;
    end else begin
      case (state)
        MIX: begin
          if (!skip_flag) begin
            buffer <= mixed_buffer;
          end
          mix_cnt <= mix_cnt + 2'd1;
          if (mix_cnt == LAST_GROUP) begin
            state   <= DONE;
            o_Valid <= 1'b1;
          end
        end
        DONE: begin
          if (i_Ready) begin
            state   <= IDLE;
            o_Valid <= 1'b0;
`ifdef AES_STATE_ZEROIZE_EN
            buffer    <= '0;
            skip_flag <= 1'b0;
`else
            buffer    <= buffer;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          o_Valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_addkey_mix_seq.sv
// Self-checking bench for inv_addkey_mix_seq: fixed vectors, back-pressure, reset abort, random blocks.
// Honours AES_STATE_ZEROIZE_EN for the post-handshake o_Data expectation.
module tb_inv_addkey_mix_seq;

  localparam int CPC     = 1;
  localparam int MIX_LAT = 4 / CPC + 1;

  logic         i_Clk = 1'b0;
  logic         i_Rst_n;
  logic         i_Valid;
  logic         o_Ready;
  logic [127:0] i_Data;
  logic [127:0] i_Key;
  logic         i_Skip_Mix;
  logic         o_Valid;
  logic         i_Ready;
  logic [127:0] o_Data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string        name;
    logic [127:0] data;
    logic [127:0] key;
    logic         skip;
    logic [127:0] expected;
  } vector_t;

  vector_t vectors[4];

  always #5 i_Clk = ~i_Clk;

  inv_addkey_mix_seq #(.COLS_PER_CYCLE(CPC)) dut (
    .i_Clk      (i_Clk),
    .i_Rst_n    (i_Rst_n),
    .i_Valid    (i_Valid),
    .o_Ready    (o_Ready),
    .i_Data     (i_Data),
    .i_Key      (i_Key),
    .i_Skip_Mix (i_Skip_Mix),
    .o_Valid    (o_Valid),
    .i_Ready    (i_Ready),
    .o_Data     (o_Data)
  );

  // Reference model: textbook GF(2^8) multiply and the inverse mixing matrix.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] c);
    logic [7:0] coef[4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [7:0] in_b[4];
    logic [7:0] acc;
    logic [31:0] r;
    for (int j = 0; j < 4; j++) in_b[j] = c[31 - 8 * j -: 8];
    for (int row = 0; row < 4; row++) begin
      acc = 8'h00;
      for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(coef[(j - row + 4) % 4], in_b[j]);
      r[31 - 8 * row -: 8] = acc;
    end
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k,
                                         input logic skip);
    logic [127:0] s = d ^ k;
    if (skip) return s;
    return {model_col(s[127:96]), model_col(s[95:64]), model_col(s[63:32]), model_col(s[31:0])};
  endfunction

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [127:0] d, input logic [127:0] k, input logic skip);
    @(negedge i_Clk);
    check_output("ready_before_load", 128'(o_Ready), 128'(1));
    i_Data     = d;
    i_Key      = k;
    i_Skip_Mix = skip;
    i_Valid    = 1'b1;
    @(posedge i_Clk);
  endtask

  // Returns the cycle count from the accept edge to the first o_Valid, 0 on timeout.
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge i_Clk);
      i_Valid = 1'b0;
      i_Ready = 1'b0;
      if (o_Valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic finish_handshake(input string name, input logic [127:0] result);
    i_Ready = 1'b1;
    @(negedge i_Clk);
    i_Ready = 1'b0;
    check_output({name, "_valid_drop"}, 128'(o_Valid), 128'(0));
    check_output({name, "_ready_idle"}, 128'(o_Ready), 128'(1));
`ifdef AES_STATE_ZEROIZE_EN
    check_output({name, "_zeroized"}, o_Data, 128'(0));
`else
    check_output({name, "_retained"}, o_Data, result);
`endif
  endtask

  task automatic run_block(input string name, input logic [127:0] d, input logic [127:0] k,
                           input logic skip, input logic [127:0] expected);
    int lat;
    apply_stimulus(d, k, skip);
    wait_valid(lat);
    check_output({name, "_latency"}, 128'(lat), 128'(skip ? 1 : MIX_LAT));
    check_output({name, "_data"}, o_Data, expected);
    finish_handshake(name, expected);
  endtask

  initial begin
    int lat;
    int emitted;
    logic [127:0] d, k, exp_a, exp_b;
    logic skip;

    vectors[0] = '{"single_col", {4{32'h8e4da1bc}}, 128'h0, 1'b0, {4{32'hdb135345}}};
    vectors[1] = '{"key_xor", {4{32'h71b25e43}}, {4{32'hffffffff}}, 1'b0, {4{32'hdb135345}}};
    vectors[2] = '{"col_order", {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'h8e4da1bc}, 128'h0,
                   1'b0, {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hdb135345}};
    vectors[3] = '{"skip_mix", 128'h0123456789abcdef0011223344556677,
                   128'h0123456789abcdef0011223344556677, 1'b1, 128'h0};

    i_Rst_n = 1'b0; i_Valid = 1'b0; i_Ready = 1'b0; i_Skip_Mix = 1'b0;
    i_Data = '0; i_Key = '0;
    repeat (3) @(negedge i_Clk);
    check_output("reset_valid", 128'(o_Valid), 128'(0));
    check_output("reset_data", o_Data, 128'(0));
    i_Rst_n = 1'b1;
    @(negedge i_Clk);
    check_output("reset_ready", 128'(o_Ready), 128'(1));

    for (int i = 0; i < 4; i++)
      run_block(vectors[i].name, vectors[i].data, vectors[i].key, vectors[i].skip,
                vectors[i].expected);

    // Back-pressure in DONE, then a same-edge handshake plus new load.
    exp_a = {4{32'hdb135345}};
    apply_stimulus({4{32'h8e4da1bc}}, 128'h0, 1'b0);
    wait_valid(lat);
    check_output("bp_latency", 128'(lat), 128'(MIX_LAT));
    for (int i = 0; i < 10; i++) begin
      check_output("bp_data_stable", o_Data, exp_a);
      check_output("bp_ready_low", 128'(o_Ready), 128'(0));
      check_output("bp_valid_high", 128'(o_Valid), 128'(1));
      @(negedge i_Clk);
    end
    d = {32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'h8e4da1bc};
    exp_b = {32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hdb135345};
    i_Data = d; i_Key = 128'h0; i_Skip_Mix = 1'b0; i_Valid = 1'b1; i_Ready = 1'b1;
    #1;
    check_output("b2b_ready", 128'(o_Ready), 128'(1));
    @(posedge i_Clk);
    wait_valid(lat);
    check_output("b2b_latency", 128'(lat), 128'(MIX_LAT));
    check_output("b2b_data", o_Data, exp_b);
    finish_handshake("b2b", exp_b);

    // Reset pulse while the block is still mixing.
    apply_stimulus({4{32'h12345678}}, {4{32'h0f0f0f0f}}, 1'b0);
    for (int i = 0; i < ((4 / CPC) < 3 ? (4 / CPC) : 3); i++) begin
      @(negedge i_Clk);
      i_Valid = 1'b0;
    end
    i_Rst_n = 1'b0;
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    check_output("abort_valid", 128'(o_Valid), 128'(0));
    check_output("abort_data", o_Data, 128'(0));
    check_output("abort_ready", 128'(o_Ready), 128'(1));
    emitted = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge i_Clk);
      if (o_Valid) emitted++;
    end
    check_output("abort_not_emitted", 128'(emitted), 128'(0));

    for (int i = 0; i < 8; i++) begin
      d    = {$urandom(), $urandom(), $urandom(), $urandom()};
      k    = {$urandom(), $urandom(), $urandom(), $urandom()};
      skip = ($urandom_range(0, 3) == 0);
      run_block("random", d, k, skip, model(d, k, skip));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
